// File: rtl/ctrl_pipe_unit.sv
// Registered RV32 control decoder with a one-entry valid/ready ID/EX output register.
// Define RISCV_M_CORE_EN to decode M-extension ops and build the MUL/DIV issue-stall FSM.
module ctrl_pipe_unit #(
  parameter int WORD_WIDTH   = 32,
  parameter int ALU_OP_WIDTH = 6,
  parameter int MUL_CYCLES   = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [WORD_WIDTH-1:0]   instr_i,
  input  logic                    instr_valid_i,
  output logic                    instr_ready_o,
  input  logic                    flush_i,
  input  logic                    ex_ready_i,
  input  logic                    div_done_i,
  output logic                    ctrl_valid_o,
  output logic [ALU_OP_WIDTH-1:0] alu_op_o,
  output logic                    write_en_o,
  output logic                    imm_o,
  output logic                    stype_o,
  output logic                    upper_o,
  output logic                    lui_shift_o,
  output logic                    pc_ula_o,
  output logic                    load_o,
  output logic                    store_o,
  output logic                    branch_o,
  output logic                    brn_inv_o,
  output logic                    jal_o,
  output logic                    jalr_o,
  output logic                    md_op_o,
  output logic                    illegal_o,
  output logic                    md_busy_o
);

  typedef struct packed {
    logic [ALU_OP_WIDTH-1:0] alu_op;
    logic write_en;
    logic imm;
    logic stype;
    logic upper;
    logic lui_shift;
    logic pc_ula;
    logic load;
    logic store;
    logic branch;
    logic brn_inv;
    logic jal;
    logic jalr;
`ifdef RISCV_M_CORE_EN
    logic md_op;
    logic md_div;
`endif
    logic illegal;
  } bundle_t;

  bundle_t    bundle_d, bundle_q;
  logic       ctrl_valid_q;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [5:0] op6;
  logic       bad;
  logic       run, accept, consume;
  logic       unused_instr;

  assign opcode       = instr_i[6:0];
  assign funct3       = instr_i[14:12];
  assign funct7       = instr_i[31:25];
  assign unused_instr = ^instr_i;

  // alu_op class in [5:4]: 00 ALU, 01 mul/div, 10 branch compare, 11 address add
  always_comb begin
    bundle_d = '0;
    op6      = 6'b110000;
    bad      = 1'b0;
    case (opcode)
      7'b0110011: begin
        op6 = {2'b00, funct7[5], funct3};
        bundle_d.write_en = 1'b1;
        if (funct7 == 7'b0000000 ||
            (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
          bad = 1'b0;
        end
`ifdef RISCV_M_CORE_EN
        else if (funct7 == 7'b0000001) begin
          op6             = {3'b010, funct3};
          bundle_d.md_op  = 1'b1;
          bundle_d.md_div = funct3[2];
        end
`endif
        else begin
          bad = 1'b1;
        end
      end
      7'b0010011: begin
        op6 = {2'b00, (funct3 == 3'b101) && funct7[5], funct3};
        bundle_d.write_en = 1'b1;
        bundle_d.imm      = 1'b1;
        if (funct3 == 3'b001)      bad = (funct7 != 7'b0000000);
        else if (funct3 == 3'b101) bad = !(funct7 == 7'b0000000 || funct7 == 7'b0100000);
      end
      7'b0000011: begin
        bundle_d.write_en = 1'b1;
        bundle_d.imm      = 1'b1;
        bundle_d.load     = 1'b1;
        bad = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      7'b0100011: begin
        bundle_d.imm   = 1'b1;
        bundle_d.stype = 1'b1;
        bundle_d.store = 1'b1;
        bad = funct3[2] || (funct3 == 3'b011);
      end
      7'b1100011: begin
        op6 = {3'b100, funct3};
        bundle_d.branch  = 1'b1;
        bundle_d.brn_inv = funct3[0];
        bad = (funct3[2:1] == 2'b01);
      end
      7'b1101111: begin
        bundle_d.write_en = 1'b1;
        bundle_d.imm      = 1'b1;
        bundle_d.pc_ula   = 1'b1;
        bundle_d.jal      = 1'b1;
      end
      7'b1100111: begin
        bundle_d.write_en = 1'b1;
        bundle_d.imm      = 1'b1;
        bundle_d.jalr     = 1'b1;
        bad = (funct3 != 3'b000);
      end
      7'b0110111: begin
        bundle_d.write_en  = 1'b1;
        bundle_d.imm       = 1'b1;
        bundle_d.upper     = 1'b1;
        bundle_d.lui_shift = 1'b1;
      end
      7'b0010111: begin
        bundle_d.write_en = 1'b1;
        bundle_d.imm      = 1'b1;
        bundle_d.upper    = 1'b1;
        bundle_d.pc_ula   = 1'b1;
      end
      default: bad = 1'b1;
    endcase
    bundle_d.alu_op = ALU_OP_WIDTH'(op6);
    if (bad) begin
      bundle_d         = '0;
      bundle_d.illegal = 1'b1;
    end
  end

  assign instr_ready_o = !rst_i && run && !flush_i && (!ctrl_valid_q || ex_ready_i);
  assign accept        = instr_valid_i && instr_ready_o;
  assign consume       = ctrl_valid_q && ex_ready_i && !flush_i;

  // Flush wins; accept also covers the same-cycle consume of the previous entry.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl_valid_q <= 1'b0;
      bundle_q     <= '0;
    end else if (flush_i) begin
      ctrl_valid_q <= 1'b0;
    end else if (accept) begin
      ctrl_valid_q <= 1'b1;
      bundle_q     <= bundle_d;
    end else if (consume) begin
      ctrl_valid_q <= 1'b0;
    end
  end

`ifdef RISCV_M_CORE_EN
  typedef enum logic [1:0] {RUN, MUL_WAIT, DIV_WAIT} state_e;
  state_e     state_q;
  logic [3:0] mul_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= RUN;
      mul_cnt_q <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (consume && bundle_q.md_op) begin
            if (bundle_q.md_div) begin
              state_q <= DIV_WAIT;
            end else if (MUL_CYCLES > 1) begin
              state_q   <= MUL_WAIT;
              mul_cnt_q <= 4'(MUL_CYCLES - 1);
            end
          end
        end
        MUL_WAIT: begin
          if (mul_cnt_q <= 4'd1) begin
            state_q   <= RUN;
            mul_cnt_q <= '0;
          end else begin
            mul_cnt_q <= mul_cnt_q - 4'd1;
          end
        end
        DIV_WAIT: if (div_done_i) state_q <= RUN;
        default:  state_q <= RUN;
      endcase
    end
  end

  assign run       = (state_q == RUN);
  assign md_busy_o = (state_q != RUN);
  assign md_op_o   = bundle_q.md_op;
`else
  logic unused_div;
  assign unused_div = div_done_i;
  assign run        = 1'b1;
  assign md_busy_o  = 1'b0;
  assign md_op_o    = 1'b0;
`endif

  assign ctrl_valid_o = ctrl_valid_q;
  assign alu_op_o     = bundle_q.alu_op;
  assign write_en_o   = bundle_q.write_en;
  assign imm_o        = bundle_q.imm;
  assign stype_o      = bundle_q.stype;
  assign upper_o      = bundle_q.upper;
  assign lui_shift_o  = bundle_q.lui_shift;
  assign pc_ula_o     = bundle_q.pc_ula;
  assign load_o       = bundle_q.load;
  assign store_o      = bundle_q.store;
  assign branch_o     = bundle_q.branch;
  assign brn_inv_o    = bundle_q.brn_inv;
  assign jal_o        = bundle_q.jal;
  assign jalr_o       = bundle_q.jalr;
  assign illegal_o    = bundle_q.illegal;

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Directed bench for ctrl_pipe_unit: decode vector table plus handshake, M-stall and flush sequences.
module tb_ctrl_pipe_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid, instr_ready, flush, ex_ready, div_done;
  logic        ctrl_valid;
  logic [5:0]  alu_op;
  logic        write_en, imm, stype, upper, lui_shift, pc_ula, load, store;
  logic        branch, brn_inv, jal, jalr, md_op, illegal, md_busy;
  logic [13:0] dut_flags;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ctrl_pipe_unit #(.WORD_WIDTH(32), .ALU_OP_WIDTH(6), .MUL_CYCLES(3)) dut (
    .clk_i(clk), .rst_i(rst), .instr_i(instr), .instr_valid_i(instr_valid),
    .instr_ready_o(instr_ready), .flush_i(flush), .ex_ready_i(ex_ready),
    .div_done_i(div_done), .ctrl_valid_o(ctrl_valid), .alu_op_o(alu_op),
    .write_en_o(write_en), .imm_o(imm), .stype_o(stype), .upper_o(upper),
    .lui_shift_o(lui_shift), .pc_ula_o(pc_ula), .load_o(load), .store_o(store),
    .branch_o(branch), .brn_inv_o(brn_inv), .jal_o(jal), .jalr_o(jalr),
    .md_op_o(md_op), .illegal_o(illegal), .md_busy_o(md_busy)
  );

  // bit order: we imm stype upper lui pc_ula load store branch brn_inv jal jalr md_op illegal
  assign dut_flags = {write_en, imm, stype, upper, lui_shift, pc_ula, load, store,
                      branch, brn_inv, jal, jalr, md_op, illegal};

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [5:0]  alu;
    logic [13:0] flags;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  localparam logic [31:0] I_ADD = 32'h003100B3;
  localparam logic [31:0] I_BEQ = 32'h00000063;
  localparam logic [31:0] I_MUL = 32'h023100B3;
  localparam logic [31:0] I_DIV = 32'h023140B3;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{"add",   I_ADD,          6'b000000, 14'b10000000000000};
    vecs[1]  = '{"beq",   I_BEQ,          6'b100000, 14'b00000000100000};
    vecs[2]  = '{"sub",   32'h403100B3,   6'b001000, 14'b10000000000000};
    vecs[3]  = '{"addi",  32'h00500093,   6'b000000, 14'b11000000000000};
    vecs[4]  = '{"lw",    32'h00002083,   6'b110000, 14'b11000010000000};
    vecs[5]  = '{"sw",    32'h00112023,   6'b110000, 14'b01100001000000};
    vecs[6]  = '{"bne",   32'h00001063,   6'b100001, 14'b00000000110000};
    vecs[7]  = '{"jal",   32'h008000EF,   6'b110000, 14'b11000100001000};
    vecs[8]  = '{"jalr",  32'h000080E7,   6'b110000, 14'b11000000000100};
    vecs[9]  = '{"lui",   32'h123450B7,   6'b110000, 14'b11011000000000};
    vecs[10] = '{"auipc", 32'h00001097,   6'b110000, 14'b11010100000000};
    vecs[11] = '{"zero",  32'h00000000,   6'b000000, 14'b00000000000001};
    vecs[12] = '{"srai",  32'h4010D093,   6'b001101, 14'b11000000000000};
    vecs[13] = '{"bf3_2", 32'h00002063,   6'b000000, 14'b00000000000001};

    rst = 1'b1; instr = I_ADD; instr_valid = 1'b1; flush = 1'b0; ex_ready = 1'b1; div_done = 1'b0;

    // reset state
    smp();
    chk("rst_ready", {31'd0, instr_ready}, 32'd0);
    chk("rst_outs", {10'd0, ctrl_valid, alu_op, dut_flags, md_busy}, 32'd0);
    tick(); rst = 1'b0;
    smp();
    chk("rel_ready", {31'd0, instr_ready}, 32'd1);
    tick(); instr_valid = 1'b0;
    smp();
    chk("pre_rst_valid", {31'd0, ctrl_valid}, 32'd1);
    rst = 1'b1; #1;
    chk("mid_rst_outs", {10'd0, ctrl_valid, alu_op, dut_flags, md_busy}, 32'd0);
    chk("mid_rst_ready", {31'd0, instr_ready}, 32'd0);
    tick(); rst = 1'b0;
    smp();
    chk("post_rst_ready", {31'd0, instr_ready}, 32'd1);
    $display("txn reset sequence done");

    // back-to-back decode stream with ex_ready held high
    for (int i = 0; i <= NV; i++) begin
      tick();
      if (i < NV) begin
        instr = vecs[i].instr; instr_valid = 1'b1;
      end else begin
        instr_valid = 1'b0;
      end
      smp();
      if (i < NV) chk($sformatf("stream_ready_%0d", i), {31'd0, instr_ready}, 32'd1);
      if (i > 0) begin
        chk({vecs[i-1].name, "_valid"}, {31'd0, ctrl_valid}, 32'd1);
        chk({vecs[i-1].name, "_alu"},   {26'd0, alu_op}, {26'd0, vecs[i-1].alu});
        chk({vecs[i-1].name, "_flags"}, {18'd0, dut_flags}, {18'd0, vecs[i-1].flags});
        $display("txn %s instr=%08h alu=%02h flags=%014b", vecs[i-1].name, vecs[i-1].instr, alu_op, dut_flags);
      end
    end
    tick();
    smp();
    chk("stream_drain", {31'd0, ctrl_valid}, 32'd0);

    // backpressure: ADD held for 3 cycles while BEQ waits
    tick(); instr = I_ADD; instr_valid = 1'b1; ex_ready = 1'b0;
    smp();
    tick(); instr = I_BEQ;
    for (int k = 0; k < 3; k++) begin
      smp();
      chk($sformatf("hold_valid_%0d", k), {31'd0, ctrl_valid}, 32'd1);
      chk($sformatf("hold_bundle_%0d", k), {24'd0, write_en, branch, alu_op}, {24'd0, 2'b10, 6'b000000});
      chk($sformatf("hold_ready_%0d", k), {31'd0, instr_ready}, 32'd0);
      tick();
    end
    instr_valid = 1'b0; ex_ready = 1'b1;
    smp();
    chk("hold_consume_ready", {31'd0, instr_ready}, 32'd1);
    tick();
    smp();
    chk("hold_consumed", {31'd0, ctrl_valid}, 32'd0);
    $display("txn backpressure sequence done");

`ifdef RISCV_M_CORE_EN
    // MUL: two stall cycles after consume
    tick(); instr = I_MUL; instr_valid = 1'b1; ex_ready = 1'b0;
    smp();
    tick(); instr_valid = 1'b0; ex_ready = 1'b1;
    smp();
    chk("mul_md_op", {30'd0, md_op, md_busy}, 32'd2);
    tick();
    for (int k = 0; k < 2; k++) begin
      smp();
      chk($sformatf("mul_wait_%0d", k), {30'd0, md_busy, instr_ready}, 32'd2);
      tick();
    end
    smp();
    chk("mul_done", {30'd0, md_busy, instr_ready}, 32'd1);
    $display("txn mul stall done");

    // reset while in MUL_WAIT
    tick(); instr = I_MUL; instr_valid = 1'b1;
    smp();
    tick(); instr_valid = 1'b0;
    smp();
    tick();
    smp();
    chk("mul_rst_pre", {31'd0, md_busy}, 32'd1);
    rst = 1'b1; #1;
    chk("mul_rst_busy", {30'd0, md_busy, instr_ready}, 32'd0);
    tick(); rst = 1'b0;
    smp();
    chk("mul_rst_ready", {30'd0, md_busy, instr_ready}, 32'd1);

    // DIV: stall until the cycle after div_done
    tick(); instr = I_DIV; instr_valid = 1'b1; ex_ready = 1'b0;
    smp();
    tick(); instr_valid = 1'b0; ex_ready = 1'b1;
    smp();
    chk("div_md_op", {30'd0, md_op, illegal}, 32'd2);
    tick();
    for (int k = 1; k <= 5; k++) begin
      if (k == 5) div_done = 1'b1;
      smp();
      chk($sformatf("div_wait_%0d", k), {30'd0, md_busy, instr_ready}, 32'd2);
      tick(); div_done = 1'b0;
    end
    smp();
    chk("div_done", {30'd0, md_busy, instr_ready}, 32'd1);
    $display("txn div stall done");
`else
    // M encodings are illegal without the M core
    tick(); instr = I_MUL; instr_valid = 1'b1; ex_ready = 1'b1;
    smp();
    tick(); instr = I_DIV;
    smp();
    chk("mul_illegal", {29'd0, ctrl_valid, md_op, illegal}, 32'd5);
    chk("mul_we", {31'd0, write_en}, 32'd0);
    tick(); instr_valid = 1'b0;
    smp();
    chk("div_illegal", {29'd0, ctrl_valid, md_op, illegal}, 32'd5);
    chk("div_busy", {30'd0, md_busy, instr_ready}, 32'd1);
    tick();
    smp();
    $display("txn m-disabled sequence done");
`endif

    // div_done outside DIV_WAIT has no effect
    div_done = 1'b1;
    tick(); div_done = 1'b0;
    smp();
    chk("stray_div_done", {30'd0, md_busy, instr_ready}, 32'd1);

    // flush with ex_ready on a pending MUL, then an illegal word
    tick(); instr = I_MUL; instr_valid = 1'b1; ex_ready = 1'b0;
    smp();
    tick(); instr = 32'h00000000; flush = 1'b1; ex_ready = 1'b1;
    smp();
    chk("flush_ready", {30'd0, ctrl_valid, instr_ready}, 32'd2);
    tick(); flush = 1'b0;
    smp();
    chk("flush_dropped", {29'd0, ctrl_valid, md_busy, instr_ready}, 32'd1);
    tick(); instr_valid = 1'b0;
    smp();
    chk("flush_next", {29'd0, ctrl_valid, illegal, write_en}, 32'd6);
    tick();
    smp();
    chk("flush_idle", {30'd0, ctrl_valid, md_busy}, 32'd0);
    $display("txn flush sequence done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
